// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath. General registers R0-R15, PC, IR, MAR, MDR, Y,
// 64-bit Z, HI and LO share one bus driven by a priority mux; the combinational ALU takes
// A = Y and B = bus.
// Build option: define DATAPATH_MULDIV_EN to include the signed multiplier and divider.
// Without it, mul/div opcodes yield zero.
module data_path (
  input  logic        clock,
  input  logic        clear,
  // bus source selects
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R0out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  // register load enables
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  // control
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Cin,
  input  logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  // observation
  output logic [31:0] BusMuxOut,
  output logic [31:0] IR
);

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpRor  = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
`ifdef DATAPATH_MULDIV_EN
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
`endif

  logic [31:0] r_q [16];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, zhi_q, zlo_q;
  logic [15:0] r_in;
  logic [31:0] bus;
  logic [63:0] c;
  logic [4:0]  sh;
  logic [32:0] sum;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign sh   = bus[4:0];
  assign sum  = {1'b0, y_q} + {1'b0, bus} + {32'b0, Cin};

  // Bus source mux; an X/Z select fails its if-test and falls through as deasserted.
  always_comb begin
    bus = '0;
    if (MDRout)        bus = mdr_q;
    else if (PCout)    bus = pc_q;
    else if (Zhighout) bus = zhi_q;
    else if (Zlowout)  bus = zlo_q;
    else if (R0out)    bus = r_q[0];
    else if (R2out)    bus = r_q[2];
    else if (R3out)    bus = r_q[3];
    else if (R4out)    bus = r_q[4];
    else if (R5out)    bus = r_q[5];
    else if (R6out)    bus = r_q[6];
    else if (R7out)    bus = r_q[7];
  end

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] prod;
  logic        [31:0] quo, rem;
  assign prod = $signed(y_q) * $signed(bus);

  // Signed divide; divide-by-zero returns all-ones quotient and the dividend as remainder.
  always_comb begin
    quo = '1;
    rem = y_q;
    if (bus != '0) begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
  end
`endif

  // ALU: A = Y, B = bus, 64-bit result; upper half zero unless the operation defines it.
  always_comb begin
    c = '0;
    case (opcode)
      OpAdd:  c = {31'b0, sum};
      OpSub:  c = {32'b0, y_q - bus - {31'b0, Cin}};
      OpAnd:  c = {32'b0, y_q & bus};
      OpOr:   c = {32'b0, y_q | bus};
      OpShr:  c = {32'b0, y_q >> sh};
      OpShra: c = {32'b0, 32'($signed(y_q) >>> sh)};
      OpShl:  c = {32'b0, y_q << sh};
      OpRor:  c = {32'b0, 32'({y_q, y_q} >> sh)};
      OpRol:  c = {32'b0, 32'(({y_q, y_q} << sh) >> 32)};
`ifdef DATAPATH_MULDIV_EN
      OpMul:  c = prod;
      OpDiv:  c = {rem, quo};
`endif
      OpNeg:  c = {32'b0, 32'(-bus)};
      OpNot:  c = {32'b0, ~bus};
      default: c = '0;
    endcase
  end

  // General-purpose register file; every enabled register captures the bus.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (r_in[i]) r_q[i] <= bus;
    end
  end

  // Special registers; IncPC wins over PCin, MDR takes memory data when Read is set.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end else begin
      if (IncPC)        pc_q <= pc_q + 32'd1;
      else if (PCin)    pc_q <= bus;
      if (IRin)         ir_q  <= bus;
      if (MARin)        mar_q <= bus;
      if (MDRin)        mdr_q <= Read ? Mdatain : bus;
      if (Yin)          y_q   <= bus;
      if (HIin)         hi_q  <= bus;
      if (LOin)         lo_q  <= bus;
      if (ZHighIn)      zhi_q <= c[63:32];
      if (ZLowIn)       zlo_q <= c[31:0];
    end
  end

  assign BusMuxOut = bus;
  assign IR        = ir_q;

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench for data_path. Stimulus pushes expected bus/IR values into a
// queue once inputs have settled; a monitor pops and compares against the live outputs.
module tb_data_path;

  logic clock = 1'b0;
  logic clear;
  logic PCout, Zhighout, Zlowout, MDRout, R0out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic IncPC, Read, Cin;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, IR;

  typedef struct {
    string       name;
    bit          sel_ir;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R0out(R0out), .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
    .R6out(R6out), .R7out(R7out),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
    .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in), .R11in(R11in),
    .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .Cin(Cin), .opcode(opcode), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .IR(IR)
  );

  // Monitor: compare each queued expectation against the selected output.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (exp_q.size() != 0);
      e   = exp_q.pop_front();
      act = e.sel_ir ? IR : BusMuxOut;
      n_checks++;
      if (act !== e.val)
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      else
        n_pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    {PCout, Zhighout, Zlowout, MDRout, R0out, R2out, R3out, R4out, R5out, R6out, R7out} = '0;
    {R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in} = '0;
    {R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in} = '0;
    {PCin, IRin, MARin, MDRin, Yin, HIin, LOin, ZHighIn, ZLowIn} = '0;
    {IncPC, Read, Cin} = '0;
    opcode  = '0;
    Mdatain = '0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input bit ir, input logic [31:0] v);
    #1;
    exp_q.push_back('{name: nm, sel_ir: ir, val: v});
    #1;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    cyc();
    idle();
  endtask

  // Y <- ya, then Z <- ALU(op, Y, b).
  task automatic alu_op(input logic [31:0] ya, input logic [31:0] b, input logic [4:0] op,
                        input logic ci);
    mdr_load(ya);
    MDRout = 1'b1; Yin = 1'b1;
    cyc();
    idle();
    mdr_load(b);
    MDRout = 1'b1; opcode = op; Cin = ci; ZLowIn = 1'b1; ZHighIn = 1'b1;
    cyc();
    idle();
  endtask

  task automatic check_z(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    Zlowout = 1'b1;
    check({nm, "_lo"}, 1'b0, lo);
    Zlowout = 1'b0; Zhighout = 1'b1;
    check({nm, "_hi"}, 1'b0, hi);
    Zhighout = 1'b0;
  endtask

  initial begin
    idle();
    clear = 1'b1;
    check("reset_bus_idle", 1'b0, 32'h0);
    check("reset_ir", 1'b1, 32'h0);
    PCout = 1'b1;
    check("reset_pc", 1'b0, 32'h0);
    PCout = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    cyc();

    // Register load through MDR
    mdr_load(32'h12);
    MDRout = 1'b1; R4in = 1'b1;
    check("load_bus", 1'b0, 32'h12);
    cyc();
    idle();
    R4out = 1'b1;
    check("r4_load", 1'b0, 32'h12);
    idle();

    // AND / OR through R3, R7
    mdr_load(32'h14); MDRout = 1'b1; R3in = 1'b1; cyc(); idle();
    mdr_load(32'h18); MDRout = 1'b1; R7in = 1'b1; cyc(); idle();
    R7out = 1'b1; Yin = 1'b1; cyc(); idle();
    R3out = 1'b1; opcode = 5'b00101; ZLowIn = 1'b1; cyc(); idle();
    Zlowout = 1'b1; R4in = 1'b1; cyc(); idle();
    R4out = 1'b1;
    check("and_r4", 1'b0, 32'h10);
    idle();
    R3out = 1'b1; opcode = 5'b00110; ZLowIn = 1'b1; cyc(); idle();
    Zlowout = 1'b1;
    check("or_zlo", 1'b0, 32'h1C);
    idle();
    R7out = 1'b1;
    check("r7_out", 1'b0, 32'h18);
    idle();

    // Arithmetic
    alu_op(32'hFFFFFFFF, 32'h1, 5'b00011, 1'b0); check_z("add_carry", 32'h1, 32'h0);
    alu_op(32'h5, 32'h3, 5'b00011, 1'b1);        check_z("add_cin", 32'h0, 32'h9);
    alu_op(32'h5, 32'h7, 5'b00100, 1'b0);        check_z("sub", 32'h0, 32'hFFFFFFFE);
    alu_op(32'h9, 32'h3, 5'b00100, 1'b1);        check_z("sub_cin", 32'h0, 32'h5);
    // Shifts and rotates of 0x80000010 by 4
    alu_op(32'h80000010, 32'h4, 5'b00111, 1'b0); check_z("shr", 32'h0, 32'h08000001);
    alu_op(32'h80000010, 32'h4, 5'b01000, 1'b0); check_z("shra", 32'h0, 32'hF8000001);
    alu_op(32'h80000010, 32'h4, 5'b01001, 1'b0); check_z("shl", 32'h0, 32'h00000100);
    alu_op(32'h80000010, 32'h4, 5'b01010, 1'b0); check_z("ror", 32'h0, 32'h08000001);
    alu_op(32'h80000010, 32'h4, 5'b01011, 1'b0); check_z("rol", 32'h0, 32'h00000108);
    alu_op(32'h0, 32'h4, 5'b10001, 1'b0);        check_z("neg", 32'h0, 32'hFFFFFFFC);
    alu_op(32'h0, 32'h4, 5'b10010, 1'b0);        check_z("not", 32'h0, 32'hFFFFFFFB);
    alu_op(32'h7, 32'h4, 5'b00000, 1'b0);        check_z("bad_op", 32'h0, 32'h0);
`ifdef DATAPATH_MULDIV_EN
    alu_op(32'hFFFFFFFE, 32'h3, 5'b01111, 1'b0); check_z("mul", 32'hFFFFFFFF, 32'hFFFFFFFA);
    alu_op(32'hFFFFFFF9, 32'h2, 5'b10000, 1'b0); check_z("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    alu_op(32'h10, 32'h0, 5'b10000, 1'b0);       check_z("div0", 32'h10, 32'hFFFFFFFF);
`else
    alu_op(32'hFFFFFFFE, 32'h3, 5'b01111, 1'b0); check_z("mul_off", 32'h0, 32'h0);
    alu_op(32'hFFFFFFF9, 32'h2, 5'b10000, 1'b0); check_z("div_off", 32'h0, 32'h0);
`endif

    // PC load, increment, precedence, wrap
    mdr_load(32'h18);
    MDRout = 1'b1; PCin = 1'b1; cyc(); idle();
    PCout = 1'b1; check("pc_load", 1'b0, 32'h18); idle();
    IncPC = 1'b1; cyc(); idle();
    PCout = 1'b1; check("pc_inc", 1'b0, 32'h19); idle();
    MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1; cyc(); idle();
    PCout = 1'b1; check("pc_inc_prio", 1'b0, 32'h1A); idle();
    mdr_load(32'hFFFFFFFF);
    MDRout = 1'b1; PCin = 1'b1; cyc(); idle();
    IncPC = 1'b1; cyc(); idle();
    PCout = 1'b1; check("pc_wrap", 1'b0, 32'h0); idle();

    // IR load, MDR from bus, priorities
    mdr_load(32'h2A1B8000);
    MDRout = 1'b1; IRin = 1'b1; cyc(); idle();
    check("ir_load", 1'b1, 32'h2A1B8000);
    mdr_load(32'h77);
    MDRout = 1'b1; PCin = 1'b1; R2in = 1'b1; cyc(); idle();
    R2out = 1'b1; check("r2_out", 1'b0, 32'h77); idle();
    mdr_load(32'h33);
    PCout = 1'b1; MDRin = 1'b1; Read = 1'b0; cyc(); idle();
    MDRout = 1'b1; check("mdr_from_bus", 1'b0, 32'h77); idle();
    mdr_load(32'h44);
    MDRout = 1'b1; PCout = 1'b1; check("prio_mdr_pc", 1'b0, 32'h44); idle();
    PCout = 1'b1; Zlowout = 1'b1; R2out = 1'b1; check("prio_pc_z", 1'b0, 32'h77); idle();

    // Asynchronous clear mid-cycle with registers loaded
    #2;
    clear = 1'b1;
    check("clr_ir", 1'b1, 32'h0);
    PCout = 1'b1; check("clr_pc", 1'b0, 32'h0); idle();
    cyc();
    MDRout = 1'b1; check("clr_mdr", 1'b0, 32'h0); idle();
    R2out = 1'b1; check("clr_r2", 1'b0, 32'h0); idle();
    check("clr_bus_idle", 1'b0, 32'h0);
    Mdatain = 32'h5; Read = 1'b1; MDRin = 1'b1; cyc(); idle();
    MDRout = 1'b1; check("clr_ignores_en", 1'b0, 32'h0); idle();
    @(negedge clock);
    clear = 1'b0;
    cyc();

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      n_checks += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_path.md
# data_path

32-bit single-bus CPU datapath: general registers R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z (ZHigh/ZLow), HI and LO, all sharing one 32-bit bus, plus a combinational ALU. The control unit (or a testbench) drives one-hot register-out/register-in strobes and a 5-bit ALU opcode, and sequences fetch/execute one step per clock. Memory is modelled by the `Mdatain` input feeding the MDR.

## Interface
- No parameters.
- `clock`  in  1  rising-edge clock for all registers.
- `clear`  in  1  asynchronous, active-high reset; all registers go to 0.
- `PCout`, `Zhighout`, `Zlowout`, `MDRout`, `R0out`, `R2out`–`R7out`  in  1 each  bus-source selects.
- `R0in`–`R15in`, `PCin`, `IRin`, `MARin`, `MDRin`, `Yin`, `HIin`, `LOin`, `ZHighIn`, `ZLowIn`  in  1 each  register load enables.
- `IncPC`  in  1  increment PC.
- `Read`  in  1  MDR input select: 1 = `Mdatain`, 0 = bus.
- `Cin`  in  1  carry-in for add/sub.
- `opcode`  in  5  ALU operation.
- `Mdatain`  in  32  memory read data.
- `BusMuxOut`  out  32  current bus value, for observation.
- `IR`  out  32  instruction register contents.

## Operation
- **Bus source priority** (first asserted wins): MDRout, PCout, Zhighout, Zlowout, R0out, R2out … R7out.
  - No select asserted: bus = 0.
  - An undriven or unknown select counts as deasserted.
- **Register loads:** each register captures the bus on a rising clock edge when its enable is 1.
  - MDR captures `Read ? Mdatain : bus` when MDRin = 1.
- **PC:**
  - IncPC = 1: PC ← PC + 1 (this takes precedence over PCin).
  - Otherwise, PCin = 1: PC ← bus.
  - PC wraps modulo 2^32.
- **ALU:** combinational; A = Y, B = bus; 64-bit result C.
  - ZLowIn loads Z[31:0] ← C[31:0].
  - ZHighIn loads Z[63:32] ← C[63:32].
  - Each half loads independently.
- **Opcodes** (upper result bits are 0 unless stated):
  - 00011 add: A + B + Cin; carry-out in C[32].
  - 00100 sub: A − B − Cin.
  - 00101 and.
  - 00110 or.
  - 00111 shr: logical right shift by B[4:0].
  - 01000 shra: arithmetic right shift by B[4:0].
  - 01001 shl: left shift by B[4:0].
  - 01010 ror: rotate right by B[4:0].
  - 01011 rol: rotate left by B[4:0].
  - 01111 mul: signed 64-bit A × B.
  - 10000 div: signed; C[31:0] = A / B quotient, C[63:32] = remainder.
    - B = 0: quotient = 0xFFFFFFFF, remainder = A.
  - 10001 neg: −B.
  - 10010 not: ~B.
  - Any other code: C = 0.
- HI and LO are load-only (no bus driver in this revision). R1 and R8–R15 are likewise load-only.

## Timing
- All loads take effect on the rising edge where the enable is high: one-cycle latency from enable to register output.
- Bus and ALU are combinational, so a register-out in cycle N can load Y or Z in the same cycle.
- `clear` is asynchronous: immediately on assertion, all registers (R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO) read 0, and `BusMuxOut` follows whatever is selected.
  - Clear asserted mid-sequence aborts the operation; enables are ignored while clear = 1.
- Simultaneous enables on the same edge all load the same bus value.
- Simultaneous out-selects are resolved by the priority order above.

## Configuration
- `DATAPATH_MULDIV_EN` defined: mul (01111) and div (10000) are implemented as above.
- Not defined: no multiplier or divider is synthesized, and those opcodes produce C = 0.

## Test plan
- **Register load:** `Mdatain`=0x12, Read=MDRin=1 for one edge; then MDRout=R4in=1 for one edge → R4 = 0x12 (bus 0x12 during the load cycle).
- **AND:** R3=0x14, R7=0x18; R7out+Yin; then R3out + opcode 00101 + ZLowIn; then Zlowout+R4in → R4 = 0x10.
- **Add carry:** Y=0xFFFFFFFF, bus=1, Cin=0, opcode 00011, both Z enables → ZLow = 0, ZHigh = 1.
- **PC:** MDR=0x18, MDRout+PCin → PC = 0x18; next cycle IncPC → PC = 0x19; IR load from MDR → `IR` = 0x2A1B8000.
- **Mul** (macro defined): Y=0xFFFFFFFE (−2), bus=3 → Z = 0xFFFFFFFF_FFFFFFFA. Without the macro → Z = 0.
- **Clear:** assert `clear` between clock edges with registers loaded → every register reads 0 before the next edge; no selects asserted → `BusMuxOut` = 0.
